// File: rtl/mem_arbiter.sv
`default_nettype none
// mem_arbiter: shares one byte-wide RAM port between IF and MEM (MEM has priority),
// serialising 8/16/32-bit accesses into little-endian byte cycles.  Rev 1.0
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_request,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_inst,
  input  logic              mem_request,
  input  logic              mem_we,
  input  logic [1:0]        mem_width,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic              gnt_mem_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [2:0]        n_q;
  logic [2:0]        idx_q;

  logic              if_done_q;
  logic              mem_done_q;
  logic [31:0]       if_inst_q;
  logic [31:0]       mem_rdata_q;
  logic [ADDR_W-1:0] ram_a_q;
  logic              ram_wr_q;
  logic [7:0]        ram_dout_q;

  logic [2:0]        idx_d;
  logic [31:0]       rdata_d;
  logic [2:0]        mem_n_d;
  logic              last_d;

  // idx_q is the byte currently on ram_a; the byte read one cycle earlier
  // (idx_q-1) is on ram_din now and is merged into rdata_d.
  always_comb begin
    idx_d   = idx_q + 3'd1;
    rdata_d = rdata_q;
    case (idx_q)
      3'd1:    rdata_d[7:0]   = ram_din;
      3'd2:    rdata_d[15:8]  = ram_din;
      3'd3:    rdata_d[23:16] = ram_din;
      3'd4:    rdata_d[31:24] = ram_din;
      default: rdata_d = rdata_q;
    endcase
    case (mem_width)
      2'd0:    mem_n_d = 3'd1;
      2'd1:    mem_n_d = 3'd2;
      default: mem_n_d = 3'd4;
    endcase
    last_d = (we_q && (idx_q == n_q - 3'd1)) || (idx_q == n_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_mem_q   <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      n_q         <= '0;
      idx_q       <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_inst_q   <= '0;
      mem_rdata_q <= '0;
      ram_a_q     <= '0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= '0;
    end else begin
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_inst_q   <= '0;
      mem_rdata_q <= '0;
      case (state_q)
        IDLE: begin
          idx_q   <= '0;
          rdata_q <= '0;
          if (mem_request) begin
            state_q    <= BUSY;
            gnt_mem_q  <= 1'b1;
            we_q       <= mem_we;
            addr_q     <= mem_addr;
            wdata_q    <= mem_wdata;
            n_q        <= mem_n_d;
            ram_a_q    <= mem_addr;
            ram_wr_q   <= mem_we;
            ram_dout_q <= mem_wdata[7:0];
          end else if (if_request) begin
            state_q    <= BUSY;
            gnt_mem_q  <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= if_addr;
            wdata_q    <= '0;
            n_q        <= 3'd4;
            ram_a_q    <= if_addr;
            ram_wr_q   <= 1'b0;
            ram_dout_q <= '0;
          end
        end
        BUSY: begin
          if (!we_q) begin
            rdata_q <= rdata_d;
          end
          if (last_d) begin
            state_q  <= DONE;
            ram_wr_q <= 1'b0;
            if (gnt_mem_q) begin
              mem_done_q  <= 1'b1;
              mem_rdata_q <= we_q ? 32'd0 : rdata_d;
            end else begin
              if_done_q <= 1'b1;
              if_inst_q <= rdata_d;
            end
          end else begin
            idx_q    <= idx_d;
            ram_wr_q <= we_q && (idx_d != n_q);
            if (idx_d != n_q) begin
              ram_a_q    <= addr_q + ADDR_W'(idx_d);
              ram_dout_q <= wdata_q[{idx_d[1:0], 3'b000} +: 8];
            end
          end
        end
        DONE: begin
          // Requests are deliberately ignored here so a held request is not re-granted early.
          state_q  <= IDLE;
          ram_wr_q <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          ram_wr_q <= 1'b0;
        end
      endcase
    end
  end

  assign if_done   = if_done_q;
  assign mem_done  = mem_done_q;
  assign if_inst   = if_inst_q;
  assign mem_rdata = mem_rdata_q;
  assign ram_a     = ram_a_q;
  assign ram_wr    = ram_wr_q;
  assign ram_dout  = ram_dout_q;

endmodule
`default_nettype wire
